// File: rtl/inst_sram.sv
// Instruction SRAM responder: single-port synchronous word memory with a
// registered CPU read port and a boot-loader FSM that streams in a program image.
module inst_sram #(
  parameter int unsigned DEPTH    = 1024,
  parameter logic [31:0] NOP_WORD = 32'h0000_0000,
  localparam int unsigned ADDR_W  = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              inst_sram_en,
  input  logic              inst_sram_wen,
  input  logic [31:0]       inst_sram_addr,
  input  logic [31:0]       inst_sram_write_data,
  output logic [31:0]       inst_sram_read_data,
  output logic              addr_err,
  input  logic              load_start,
  input  logic              load_valid,
  input  logic              load_last,
  input  logic [31:0]       load_data,
  output logic              load_busy,
  output logic              load_done,
  output logic [ADDR_W:0]   load_count
);

  localparam logic [0:0]      S_IDLE    = 1'b0;
  localparam logic [0:0]      S_LOAD    = 1'b1;
  localparam logic [ADDR_W:0] CNT_LAST  = (ADDR_W+1)'(DEPTH - 1);
  localparam logic [ADDR_W:0] CNT_ONE   = (ADDR_W+1)'(1);

  logic [31:0]       r_mem [DEPTH];
  logic [0:0]        r_state;
  logic [31:0]       r_read_data;
  logic              r_addr_err;
  logic              r_load_done;
  logic [ADDR_W:0]   r_load_count;

  logic              w_bad;
  logic              w_loading;
  logic [ADDR_W-1:0] w_idx;
  logic [ADDR_W-1:0] w_ld_idx;
  logic              w_ld_we;
  logic              w_cpu_we;
  logic              w_ld_end;

  assign w_bad     = (inst_sram_addr[1:0] != 2'b00) ||
                     ((inst_sram_addr >> (ADDR_W + 2)) != '0);
  assign w_loading = (r_state == S_LOAD);
  assign w_idx     = inst_sram_addr[ADDR_W+1:2];
  assign w_ld_idx  = r_load_count[ADDR_W-1:0];
  // Loader and CPU writes are mutually exclusive by FSM state, so one write port suffices.
  assign w_ld_we   = w_loading && load_valid && !rst;
  assign w_cpu_we  = !w_loading && inst_sram_en && inst_sram_wen && !w_bad && !rst;
  assign w_ld_end  = load_valid && (load_last || (r_load_count == CNT_LAST));

  always_ff @(posedge clk) begin
    if (w_ld_we) begin
      r_mem[w_ld_idx] <= load_data;
    end else if (w_cpu_we) begin
      r_mem[w_idx] <= inst_sram_write_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_read_data <= '0;
      r_addr_err  <= 1'b0;
    end else begin
      r_addr_err <= inst_sram_en && w_bad;
      if (inst_sram_en && !inst_sram_wen) begin
        r_read_data <= (w_bad || w_loading) ? NOP_WORD : r_mem[w_idx];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_load_count <= '0;
      r_load_done  <= 1'b0;
    end else begin
      r_load_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (load_start) begin
            r_state      <= S_LOAD;
            r_load_count <= '0;
          end
        end
        S_LOAD: begin
          if (load_valid) begin
            r_load_count <= r_load_count + CNT_ONE;
          end
          if (w_ld_end) begin
            r_state     <= S_IDLE;
            r_load_done <= 1'b1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign inst_sram_read_data = r_read_data;
  assign addr_err            = r_addr_err;
  assign load_busy           = w_loading;
  assign load_done           = r_load_done;
  assign load_count          = r_load_count;

endmodule

// File: tb/tb_inst_sram.sv
// Testbench for inst_sram: directed boot-load/CPU scenarios followed by random
// traffic, all checked each cycle against a behavioural memory/loader model.
module tb_inst_sram;

  localparam int unsigned DEPTH  = 1024;
  localparam int unsigned ADDR_W = $clog2(DEPTH);
  localparam logic [31:0] NOP    = 32'h0000_0013;

  logic              clk = 1'b0;
  logic              rst;
  logic              en, wen;
  logic [31:0]       addr, wdata;
  logic [31:0]       rdata;
  logic              err;
  logic              ls, lv, ll;
  logic [31:0]       ldata;
  logic              busy, done;
  logic [ADDR_W:0]   count;

  int checks = 0;
  int errors = 0;

  // Reference model state
  logic [31:0] m_mem   [DEPTH];
  bit          m_known [DEPTH];
  bit          m_loading;
  int unsigned m_count;
  logic [31:0] m_rd;
  bit          m_rd_known;
  bit          m_err, m_done;

  inst_sram #(.DEPTH(DEPTH), .NOP_WORD(NOP)) dut (
    .clk                  (clk),
    .rst                  (rst),
    .inst_sram_en         (en),
    .inst_sram_wen        (wen),
    .inst_sram_addr       (addr),
    .inst_sram_write_data (wdata),
    .inst_sram_read_data  (rdata),
    .addr_err             (err),
    .load_start           (ls),
    .load_valid           (lv),
    .load_last            (ll),
    .load_data            (ldata),
    .load_busy            (busy),
    .load_done            (done),
    .load_count           (count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Model: one clock edge's worth of behaviour from the inputs seen at that edge.
  task automatic model_step();
    bit          bad;
    int unsigned widx;
    bad  = (addr[1:0] != 2'b00) || (addr >= DEPTH * 4);
    widx = addr >> 2;
    if (rst) begin
      m_rd = '0; m_rd_known = 1; m_err = 0; m_done = 0; m_count = 0; m_loading = 0;
    end else begin
      m_err  = en && bad;
      m_done = 0;
      if (en && !wen) begin
        if (m_loading || bad) begin
          m_rd = NOP; m_rd_known = 1;
        end else begin
          m_rd = m_mem[widx]; m_rd_known = m_known[widx];
        end
      end else if (en && wen && !m_loading && !bad) begin
        m_mem[widx] = wdata; m_known[widx] = 1;
      end
      if (m_loading) begin
        if (lv) begin
          m_mem[m_count] = ldata; m_known[m_count] = 1;
          m_count++;
          if (ll || m_count == DEPTH) begin
            m_loading = 0; m_done = 1;
          end
        end
      end else if (ls) begin
        m_loading = 1; m_count = 0;
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    if (m_rd_known) chk("read_data", rdata, m_rd);
    chk("addr_err",   32'(err),   32'(m_err));
    chk("load_busy",  32'(busy),  32'(m_loading));
    chk("load_done",  32'(done),  32'(m_done));
    chk("load_count", 32'(count), m_count);
  endtask

  task automatic cyc(input logic i_en, input logic i_wen, input logic [31:0] i_addr,
                     input logic [31:0] i_wd, input logic i_ls, input logic i_lv,
                     input logic i_ll, input logic [31:0] i_ld);
    en = i_en; wen = i_wen; addr = i_addr; wdata = i_wd;
    ls = i_ls; lv = i_lv; ll = i_ll; ldata = i_ld;
    tick();
  endtask

  task automatic rd(input logic [31:0] a);
    cyc(1, 0, a, '0, 0, 0, 0, '0);
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    cyc(1, 1, a, d, 0, 0, 0, '0);
  endtask

  task automatic idle();
    cyc(0, 0, '0, '0, 0, 0, 0, '0);
  endtask

  initial begin
    logic [31:0] img [4];
    logic [31:0] ra;
    int unsigned r;
    img[0] = 32'h11; img[1] = 32'h22; img[2] = 32'h33; img[3] = 32'h44;
    for (int unsigned i = 0; i < DEPTH; i++) m_known[i] = 0;
    m_rd_known = 0; m_loading = 0; m_count = 0;

    // T1: reset
    rst = 1;
    idle();
    rst = 0;
    chk("T1_read_data", rdata, 32'h0);
    chk("T1_count", 32'(count), 32'h0);

    // T2: four-word load then read back
    cyc(0, 0, '0, '0, 1, 0, 0, '0);
    for (int unsigned i = 0; i < 4; i++) cyc(0, 0, '0, '0, 0, 1, (i == 3), img[i]);
    chk("T2_done", 32'(done), 32'h1);
    chk("T2_count", 32'(count), 32'h4);
    idle();
    for (int unsigned i = 0; i < 4; i++) begin
      rd(32'(i * 4));
      chk("T2_read", rdata, img[i]);
    end

    // T3: write then read, no write-through
    wr(32'h10, 32'hDEAD_BEEF);
    chk("T3_hold", rdata, 32'h44);
    rd(32'h10);
    chk("T3_read", rdata, 32'hDEAD_BEEF);

    // T4: misaligned and out-of-range accesses
    rd(32'h2);
    chk("T4_mis_rd", rdata, NOP);
    chk("T4_mis_err", 32'(err), 32'h1);
    idle();
    chk("T4_err_clear", 32'(err), 32'h0);
    rd(32'h4000);
    chk("T4_oor_err", 32'(err), 32'h1);
    wr(32'h4000, 32'h0BAD_0BAD);
    rd(32'h0);
    chk("T4_mem0", rdata, 32'h11);

    // T5: full-depth load without load_last, CPU read during load
    cyc(0, 0, '0, '0, 1, 0, 0, '0);
    rd(32'h0);
    chk("T5_rd_during_load", rdata, NOP);
    for (int unsigned i = 0; i < DEPTH; i++) cyc(0, 0, '0, '0, 0, 1, 0, $urandom);
    chk("T5_done", 32'(done), 32'h1);
    chk("T5_count", 32'(count), DEPTH);
    cyc(0, 0, '0, '0, 0, 1, 1, 32'hFFFF_FFFF);
    chk("T5_count_hold", 32'(count), DEPTH);
    rd(32'((DEPTH - 1) * 4));
    rd(32'h0);

    // T6: reset in the middle of a load
    cyc(0, 0, '0, '0, 1, 0, 0, '0);
    cyc(0, 0, '0, '0, 0, 1, 0, 32'hA1);
    cyc(0, 0, '0, '0, 0, 1, 0, 32'hA2);
    rst = 1;
    idle();
    rst = 0;
    chk("T6_count", 32'(count), 32'h0);
    chk("T6_busy", 32'(busy), 32'h0);
    idle();
    rd(32'h0);
    chk("T6_word0", rdata, 32'hA1);
    rd(32'h4);
    chk("T6_word1", rdata, 32'hA2);

    // Random traffic
    for (int unsigned n = 0; n < 500; n++) begin
      r = $urandom_range(0, 9);
      if (r <= 6)      ra = 32'($urandom_range(0, 63) * 4);
      else if (r == 7) ra = 32'($urandom_range(0, 63) * 4 + $urandom_range(1, 3));
      else if (r == 8) ra = (32'($urandom) | 32'h0000_1000) & 32'hFFFF_FFFC;
      else             ra = 32'($urandom_range(0, DEPTH - 1) * 4);
      cyc($urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0, ra, $urandom,
          $urandom_range(0, 19) == 0, $urandom_range(0, 1) == 1,
          $urandom_range(0, 7) == 0, $urandom);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
